// File: rtl/signed_seq_div.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per clock.
// Operates on magnitudes and applies the signs in a final fix-up cycle.
module signed_seq_div #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   quotient,
  output logic [W-1:0]     remainder,
  output logic             dbz,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(2*W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nx;

  // Handshake: start is a request qualified only by IDLE (busy=0); the
  // accepting edge captures the operands; done is a one-cycle result strobe.
  logic            accept;
  logic            last_iter;

  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  dd_mag;     // dividend magnitude, becomes the quotient magnitude
  logic [W-1:0]    dv_mag;
  logic [W-1:0]    prem;       // partial remainder; always below dv_mag between iterations
  logic            sign_q;
  logic            sign_r;
  logic            zero_div;

  logic [2*W-1:0]  dividend_abs;
  logic [W-1:0]    divisor_abs;
  logic [W:0]      shifted;
  logic [W:0]      trial;
  logic            trial_ok;
  logic [2*W-1:0]  q_fix;
  logic [W-1:0]    r_fix;
  logic            ovf_fix;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(2*W-1)) begin
          last_iter = 1'b1;
          state_nx  = FIX;
        end
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dividend_abs = dividend[2*W-1] ? -dividend : dividend;
    divisor_abs  = divisor[W-1]    ? -divisor  : divisor;
    shifted      = {prem, dd_mag[2*W-1]};
    trial        = shifted - {1'b0, dv_mag};
    trial_ok     = ~trial[W];
    q_fix        = sign_q ? -dd_mag : dd_mag;
    r_fix        = sign_r ? -prem : prem;
    // Only -2^(2W-1) / -1 yields a positive magnitude that does not fit.
    ovf_fix      = ~sign_q & dd_mag[2*W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dd_mag    <= '0;
      dv_mag    <= '0;
      prem      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_div  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dd_mag   <= dividend_abs;
        dv_mag   <= divisor_abs;
        sign_q   <= dividend[2*W-1] ^ divisor[W-1];
        sign_r   <= dividend[2*W-1];
        zero_div <= (divisor == '0);
        prem     <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
      end
      if (state == CALC) begin
        prem   <= trial_ok ? trial[W-1:0] : shifted[W-1:0];
        dd_mag <= {dd_mag[2*W-2:0], trial_ok};
        cnt    <= last_iter ? '0 : cnt + CW'(1);
      end
      if (state == FIX) begin
        done <= 1'b1;
        busy <= 1'b0;
        if (zero_div) begin
          quotient  <= '0;
          remainder <= '0;
          dbz       <= 1'b1;
          ovf       <= 1'b0;
        end else begin
          quotient  <= q_fix;
          remainder <= r_fix;
          dbz       <= 1'b0;
          ovf       <= ovf_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_seq_div.sv
// Bench for signed_seq_div: directed vectors, an arithmetic reference model and
// a per-cycle compare of busy/done/results against a scoreboard queue.
module tb_signed_seq_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  dividend;
  logic [3:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [3:0]  remainder;
  logic        dbz;
  logic        ovf;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Entry: {done_cycle[15:0], quotient[7:0], remainder[3:0], dbz, ovf}
  logic [29:0] exp_q[$];
  logic [13:0] last_res = '0;
  logic [29:0] head;
  logic        exp_busy;
  logic        exp_done;

  signed_seq_div #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] model(input logic [7:0] a, input logic [3:0] b);
    int ai, bi, qi, ri;
    ai = $signed(a);
    bi = $signed(b);
    if (bi == 0) return {8'd0, 4'd0, 1'b1, 1'b0};
    qi = ai / bi;
    ri = ai % bi;
    return {qi[7:0], ri[3:0], 1'b0, (qi > 127)};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b);
    int lat;
    lat = (4'(b) == 4'd0) ? 1 : 9;
    exp_q.push_back({16'(cyc + lat), model(8'(a), 4'(b))});
  endtask

  task automatic issue(input int a, input int b);
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    step();
    push(a, b);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    head     = (exp_q.size() > 0) ? exp_q[0] : '0;
    exp_done = (exp_q.size() > 0) && (cyc == int'(head[29:14]));
    exp_busy = (exp_q.size() > 0) && (cyc <  int'(head[29:14]));
    check("busy", {13'd0, busy}, {13'd0, exp_busy});
    check("done", {13'd0, done}, {13'd0, exp_done});
    if (exp_done) begin
      last_res = head[13:0];
      void'(exp_q.pop_front());
    end
    check("result", {quotient, remainder, dbz, ovf}, last_res);
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // hand-computed values pinning the reference model
    check("pin 100/7",   model(8'd100, 4'd7),    {8'd14,  4'd2, 2'b00});
    check("pin -100/7",  model(8'h9C,  4'd7),    {8'hF2,  4'hE, 2'b00});
    check("pin 7/-3",    model(8'd7,   4'hD),    {8'hFE,  4'd1, 2'b00});
    check("pin -56/7",   model(8'hC8,  4'd7),    {8'hF8,  4'd0, 2'b00});
    check("pin -128/-1", model(8'h80,  4'hF),    {8'h80,  4'd0, 2'b01});
    check("pin -128/1",  model(8'h80,  4'd1),    {8'h80,  4'd0, 2'b00});
    check("pin 45/0",    model(8'd45,  4'd0),    {8'd0,   4'd0, 2'b10});

    repeat (3) step();
    rst_n = 1'b1;
    step();

    issue(100, 7);   wait_idle();
    issue(-100, 7);  wait_idle();
    issue(7, -3);    wait_idle();
    issue(-56, 7);   wait_idle();
    issue(-128, -1); wait_idle();
    issue(-128, 1);  wait_idle();
    issue(45, 0);    wait_idle();
    issue(-7, 2);    wait_idle();

    // start pulsed mid-division with new operands must be ignored
    issue(20, 3);
    step();
    step();
    dividend = 8'(-90);
    divisor  = 4'(5);
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_idle();

    // start held through done: second division accepted in the done cycle
    dividend = 8'(77);
    divisor  = 4'(-6);
    start    = 1'b1;
    step();
    push(77, -6);
    dividend = 8'(-33);
    divisor  = 4'(4);
    repeat (9) step();
    step();
    push(-33, 4);
    start = 1'b0;
    wait_idle();

    // reset mid-division aborts, then a fresh division completes
    issue(50, 3);
    repeat (3) step();
    rst_n = 1'b0;
    exp_q.delete();
    last_res = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    issue(50, 3);
    wait_idle();

    // multiplier round trip
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        if (b != 0) begin
          check("model round trip", model(8'(a * b), 4'(b)), {8'(a), 4'd0, 2'b00});
          issue(a * b, b);
          wait_idle();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
